// File: rtl/life_ctrl_pkg.sv
// Shared declarations for the Life PE array and its generation controller.
// Controller states and loader timing live next to the array geometry.
package life_ctrl_pkg;

  localparam int ARRAY_ROWS = 16;
  localparam int ARRAY_COLS = 16;

  typedef enum logic {
    CELL_DEAD  = 1'b0,
    CELL_ALIVE = 1'b1
  } cell_t;

  typedef logic [ARRAY_COLS-1:0] row_t;

  // The loader writes 13 words and then needs one cycle to return to idle.
  localparam int LOAD_CYCLES_DEF = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_RUNNING = 3'd3,
    ST_STEP    = 3'd4
  } life_state_t;

endpackage

// File: rtl/life_ctrl_if.sv
// Button/period inputs and loader/array control outputs of the generation controller.
// The master side drives buttons and period; the slave side is the controller.
interface life_ctrl_if #(
  parameter int PERIOD_BITS = 24,
  parameter int GEN_BITS    = 16
);
  logic                   btn_load;
  logic                   btn_run;
  logic                   btn_step;
  logic [PERIOD_BITS-1:0] period;
  logic                   enb;
  logic                   run;
  logic                   trigger;
  logic                   busy;
  logic [GEN_BITS-1:0]    gen_count;

  modport master (
    output btn_load, btn_run, btn_step, period,
    input  enb, run, trigger, busy, gen_count
  );

  modport slave (
    input  btn_load, btn_run, btn_step, period,
    output enb, run, trigger, busy, gen_count
  );
endinterface

// File: rtl/life_ctrl_btn_edge.sv
// Rising-edge detector for an already synchronized button level.
// Edge is combinational from the live input and last cycle's registered copy.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_edge
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_btn;
  end

  assign o_edge = i_btn & ~r_prev;
endmodule

// File: rtl/life_ctrl.sv
// Generation controller: sequences pattern loads, free-run and single-step of the PE array.
// All outputs registered; an edge seen in cycle N is answered in cycle N+1.
module life_ctrl
  import life_ctrl_pkg::*;
#(
  parameter int PERIOD_BITS = 24,
  parameter int GEN_BITS    = 16,
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  life_ctrl_if.slave  bus
);
  localparam int LCNT_BITS = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LCNT_BITS-1:0] LCNT_LAST = LCNT_BITS'(LOAD_CYCLES - 1);

  logic w_load_edge;
  logic w_run_edge;
  logic w_step_edge;

  btn_edge u_edge_load (.clk(clk), .reset(reset), .i_btn(bus.btn_load), .o_edge(w_load_edge));
  btn_edge u_edge_run  (.clk(clk), .reset(reset), .i_btn(bus.btn_run),  .o_edge(w_run_edge));
  btn_edge u_edge_step (.clk(clk), .reset(reset), .i_btn(bus.btn_step), .o_edge(w_step_edge));

  life_state_t            r_state;
  life_state_t            w_state_nxt;
  logic                   r_enb,     w_enb_nxt;
  logic                   r_run,     w_run_nxt;
  logic                   r_trigger, w_trigger_nxt;
  logic                   r_busy,    w_busy_nxt;
  logic [GEN_BITS-1:0]    r_gen,     w_gen_nxt;
  logic [PERIOD_BITS-1:0] r_timer,   w_timer_nxt;
  logic [LCNT_BITS-1:0]   r_lcnt,    w_lcnt_nxt;
  logic [PERIOD_BITS-1:0] w_limit;

  // A period of 0 behaves like 1: fire every cycle.
  assign w_limit = (bus.period == '0) ? '0 : bus.period - PERIOD_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_enb_nxt     = 1'b0;
    w_run_nxt     = 1'b0;
    w_trigger_nxt = 1'b0;
    w_busy_nxt    = 1'b0;
    w_gen_nxt     = r_gen;
    w_timer_nxt   = r_timer;
    w_lcnt_nxt    = r_lcnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_load_edge) begin
          w_state_nxt = ST_LOAD;
          w_enb_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_gen_nxt   = '0;
          w_lcnt_nxt  = '0;
        end
      end
      ST_LOAD: begin
        if (r_lcnt == LCNT_LAST) begin
          w_state_nxt = ST_PAUSED;
          w_lcnt_nxt  = '0;
        end else begin
          w_busy_nxt  = 1'b1;
          w_lcnt_nxt  = r_lcnt + LCNT_BITS'(1);
        end
      end
      ST_PAUSED: begin
        if (w_load_edge) begin
          w_state_nxt = ST_LOAD;
          w_enb_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_gen_nxt   = '0;
          w_lcnt_nxt  = '0;
        end else if (w_run_edge) begin
          w_state_nxt = ST_RUNNING;
          w_run_nxt   = 1'b1;
          w_timer_nxt = '0;
        end else if (w_step_edge) begin
          w_state_nxt   = ST_STEP;
          w_run_nxt     = 1'b1;
          w_trigger_nxt = 1'b1;
          w_gen_nxt     = r_gen + GEN_BITS'(1);
        end
      end
      ST_RUNNING: begin
        if (w_load_edge) begin
          w_state_nxt = ST_LOAD;
          w_enb_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_gen_nxt   = '0;
          w_lcnt_nxt  = '0;
          w_timer_nxt = '0;
        end else if (w_run_edge) begin
          w_state_nxt = ST_PAUSED;
          w_timer_nxt = '0;
        end else begin
          w_run_nxt = 1'b1;
          // >= so a shortened period still fires on the next cycle.
          if (r_timer >= w_limit) begin
            w_trigger_nxt = 1'b1;
            w_gen_nxt     = r_gen + GEN_BITS'(1);
            w_timer_nxt   = '0;
          end else begin
            w_timer_nxt   = r_timer + PERIOD_BITS'(1);
          end
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_PAUSED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enb     <= 1'b0;
      r_run     <= 1'b0;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
      r_gen     <= '0;
      r_timer   <= '0;
      r_lcnt    <= '0;
    end else begin
      r_enb     <= w_enb_nxt;
      r_run     <= w_run_nxt;
      r_trigger <= w_trigger_nxt;
      r_busy    <= w_busy_nxt;
      r_gen     <= w_gen_nxt;
      r_timer   <= w_timer_nxt;
      r_lcnt    <= w_lcnt_nxt;
    end
  end

  assign bus.enb       = r_enb;
  assign bus.run       = r_run;
  assign bus.trigger   = r_trigger;
  assign bus.busy      = r_busy;
  assign bus.gen_count = r_gen;
endmodule

// File: tb/tb_life_ctrl.sv
// Bench for life_ctrl: directed scenarios then random buttons/period/reset,
// two DUTs (16-bit and 4-bit generation counters) checked against one behavioural model.
module tb_life_ctrl;
  localparam int PB    = 24;
  localparam int LOADC = 14;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_PAUSED = 2;
  localparam int M_RUN    = 3;
  localparam int M_STEP   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_ctrl_if #(.PERIOD_BITS(PB), .GEN_BITS(16)) b16 ();
  life_ctrl_if #(.PERIOD_BITS(PB), .GEN_BITS(4))  b4  ();

  life_ctrl #(.PERIOD_BITS(PB), .GEN_BITS(16), .LOAD_CYCLES(LOADC)) dut16 (
    .clk(clk), .reset(reset), .bus(b16.slave));
  life_ctrl #(.PERIOD_BITS(PB), .GEN_BITS(4), .LOAD_CYCLES(LOADC)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave));

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int period_v = 4;

  // Behavioural model: mode, remaining load cycles, cycles since last trigger, generation count.
  int m_mode = M_IDLE;
  int m_load_left = 0;
  int m_elapsed = 0;
  int m_gen = 0;
  bit p_l = 0, p_r = 0, p_s = 0;
  bit e_enb = 0, e_run = 0, e_trig = 0, e_busy = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic start_load();
    m_mode      = M_LOAD;
    m_load_left = LOADC;
    e_enb       = 1'b1;
    m_gen       = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit s, input bit rst, input int p);
    bit le, re, se;
    le = l & ~p_l;
    re = r & ~p_r;
    se = s & ~p_s;
    e_enb  = 1'b0;
    e_trig = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_gen = 0; m_elapsed = 0; m_load_left = 0;
      p_l = 0; p_r = 0; p_s = 0;
    end else begin
      case (m_mode)
        M_IDLE:   if (le) start_load();
        M_LOAD: begin
          m_load_left--;
          if (m_load_left == 0) m_mode = M_PAUSED;
        end
        M_PAUSED: begin
          if (le) start_load();
          else if (re) begin m_mode = M_RUN; m_elapsed = 0; end
          else if (se) begin m_mode = M_STEP; e_trig = 1'b1; m_gen++; end
        end
        M_RUN: begin
          if (le) start_load();
          else if (re) m_mode = M_PAUSED;
          else begin
            m_elapsed++;
            if (m_elapsed >= ((p == 0) ? 1 : p)) begin
              e_trig = 1'b1; m_gen++; m_elapsed = 0;
            end
          end
        end
        default: m_mode = M_PAUSED;
      endcase
      p_l = l; p_r = r; p_s = s;
    end
    e_run  = (m_mode == M_RUN) || (m_mode == M_STEP);
    e_busy = (m_mode == M_LOAD);
  endtask

  task automatic check_all();
    chk_eq("enb",      b16.enb,       e_enb);
    chk_eq("run",      b16.run,       e_run);
    chk_eq("trigger",  b16.trigger,   e_trig);
    chk_eq("busy",     b16.busy,      e_busy);
    chk_eq("gen16",    b16.gen_count, m_gen & 32'hFFFF);
    chk_eq("trig_run", b16.trigger & ~b16.run, 0);
    chk_eq("enb4",     b4.enb,        e_enb);
    chk_eq("run4",     b4.run,        e_run);
    chk_eq("trigger4", b4.trigger,    e_trig);
    chk_eq("busy4",    b4.busy,       e_busy);
    chk_eq("gen4",     b4.gen_count,  m_gen & 32'hF);
  endtask

  task automatic tick(input bit l, input bit r, input bit s, input bit rst);
    reset = rst;
    b16.btn_load = l; b16.btn_run = r; b16.btn_step = s; b16.period = PB'(period_v);
    b4.btn_load  = l; b4.btn_run  = r; b4.btn_step  = s; b4.period  = PB'(period_v);
    model_step(l, r, s, rst, period_v);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic hold(input bit l, input bit r, input bit s, input bit rst, input int n);
    for (int k = 0; k < n; k++) tick(l, r, s, rst);
  endtask

  bit rl, rr, rs, rx;

  initial begin
    reset = 1'b1;
    b16.btn_load = 0; b16.btn_run = 0; b16.btn_step = 0; b16.period = PB'(4);
    b4.btn_load  = 0; b4.btn_run  = 0; b4.btn_step  = 0; b4.period  = PB'(4);
    @(negedge clk);
    check_all();

    hold(0, 0, 0, 1, 2);
    hold(0, 1, 0, 0, 1); hold(0, 0, 1, 0, 1); hold(0, 0, 0, 0, 2);  // ignored in IDLE
    hold(1, 0, 0, 0, 1); hold(0, 0, 0, 0, 16);                      // load
    period_v = 4;
    hold(0, 1, 0, 0, 1); hold(0, 0, 0, 0, 14);                      // free-run
    hold(0, 1, 0, 0, 1); hold(0, 0, 0, 0, 3);                       // pause
    hold(0, 0, 1, 0, 1); hold(0, 0, 0, 0, 3);                       // single step
    hold(1, 1, 0, 0, 1); hold(0, 0, 0, 0, 16);                      // load beats run
    period_v = 0;
    hold(0, 1, 0, 0, 1); hold(0, 0, 0, 0, 20);                      // every cycle, 4-bit wraps
    period_v = 6;
    hold(0, 0, 0, 0, 4);
    period_v = 2;
    hold(0, 0, 0, 0, 5);
    hold(0, 0, 0, 1, 1); hold(0, 0, 0, 0, 2);                       // reset mid-run
    hold(1, 0, 0, 0, 1); hold(0, 0, 0, 0, 5);
    hold(0, 0, 0, 1, 1); hold(0, 0, 0, 0, 2);                       // reset mid-load

    rl = 0; rr = 0; rs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) rl = ~rl;
      if ($urandom_range(0, 9) == 0)  rr = ~rr;
      if ($urandom_range(0, 4) == 0)  rs = ~rs;
      rx = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) period_v = $urandom_range(0, 7);
      tick(rl, rr, rs, rx);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
